matmul_dot_sched: RTL and testbench
===================================

Name: matmul_dot_sched

Overview:
- Scheduler that computes C = A x B by driving a single shared vec_dot datapath.
- Walks the result matrix in row-major order. For each element (i, j) it issues read addresses for row i of A and column j of B to external operand buffers.
- Tags each issue so that the vec_dot output leaves the block labelled with its (i, j).
- A credit-controlled result FIFO absorbs downstream backpressure, because the vec_dot pipeline itself cannot stall.

Parameters:
- FLOAT_WIDTH, 32: width of one float result.
- ROW_BITS, 4: width of row count and row index.
- COL_BITS, 4: width of column count and column index.
- RD_LATENCY, 1: cycles from a_rd_en/b_rd_en until the operand vectors are valid at the vec_dot lhs/rhs inputs.
- DOT_LATENCY, 4: cycles from lhs/rhs valid until vec_dot out is valid.
- FIFO_DEPTH, 8: result FIFO entries. Must be a power of two and at least 2.

Ports:
- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- start, input, 1: begin a job. Sampled only in IDLE.
- m_rows, input, ROW_BITS: rows of C. Latched on accepted start.
- n_cols, input, COL_BITS: columns of C. Latched on accepted start.
- busy, output, 1: high in every state except IDLE.
- done, output, 1: one-cycle pulse when a job completes.
- a_rd_en, output, 1: A-row read strobe.
- a_rd_addr, output, ROW_BITS: A row index i.
- b_rd_en, output, 1: B-column read strobe.
- b_rd_addr, output, COL_BITS: B column index j.
- dot_out, input, FLOAT_WIDTH: vec_dot out.
- res_valid, output, 1: result available.
- res_ready, input, 1: downstream accepts the result.
- res_data, output, FLOAT_WIDTH: C[i][j].
- res_row, output, ROW_BITS: i.
- res_col, output, COL_BITS: j.
- res_last, output, 1: marks the final element of the job.

Behaviour:
- Reset values:
  - All outputs are 0. State is IDLE, counters are 0, credits = FIFO_DEPTH.
  - Tag pipeline valid bits and the FIFO are cleared.
- Reset mid-job discards all in-flight and queued results. No done pulse is produced.
- States are IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - start latches m_rows and n_cols, clears i and j.
  - Next state is ISSUE. If either dimension is 0, next state is DONE directly and nothing is issued.
  - start in any other state is ignored.
- ISSUE:
  - An issue happens in a cycle when credits > 0.
  - On an issue: a_rd_en = b_rd_en = 1, a_rd_addr = i, b_rd_addr = j.
  - Both strobes are always identical. Addresses hold their last value when the strobes are low.
  - After an issue, j increments. When j = n_cols-1, j wraps to 0 and i increments.
  - The issue with i = m_rows-1 and j = n_cols-1 is tagged last, and next state is DRAIN.
  - When credits = 0, nothing is issued and the counters hold.
- Tag pipeline:
  - Shift register of depth RD_LATENCY + DOT_LATENCY carrying {valid, i, j, last}.
  - When a valid tag exits, dot_out is written into the FIFO together with the tag in that same cycle.
- FIFO:
  - Show-ahead. res_valid rises the cycle after the write.
  - Pop occurs on res_valid && res_ready.
  - res_data, res_row, res_col and res_last stay stable while res_valid && !res_ready.
- Credits:
  - Decrement on issue, increment on pop. Issue and pop in the same cycle leave credits unchanged.
  - Credits never exceed FIFO_DEPTH and never go below 0.
  - The FIFO therefore can never overflow. An overflow indicates a design error; assert on it.
- DRAIN → DONE when there are no valid tags in flight, the FIFO is empty, and the last element has been popped.
- DONE: done = 1 for exactly one cycle, then IDLE. busy falls in the cycle after done.
- A start arriving in the same cycle as done is ignored.
- Throughput: with res_ready held at 1, one issue per cycle and one result per cycle.
- First result latency: start accepted in cycle T gives the first issue at T+1 and the first res_valid at T+2+RD_LATENCY+DOT_LATENCY (T+7 with default parameters).

Decomposition:
- Shared package matmul_pkg holds:
  - FLOAT_WIDTH.
  - The state encoding constants.
  - The tag field layout: valid, row, col and last bit positions, plus the TAG_WIDTH macro.
- One sub-module: sched_result_fifo. Synchronous, show-ahead, parameterised by width and depth, with async active-low reset, push/pop/empty/full.

Test Plan:
- m_rows=2, n_cols=3, res_ready=1, start at T:
  - Issues (0,0) (0,1) (0,2) (1,0) (1,1) (1,2) occur on T+1..T+6.
  - res_valid runs on T+7..T+12 with a matching row/col on each result.
  - res_last is high only with (1,2). done is high at T+14.
- m_rows=4, n_cols=4, res_ready=0:
  - Exactly 8 issues, then a_rd_en stays 0.
  - Raising res_ready drains all 16 results in row-major order, then done pulses once.
- Toggle res_ready every cycle during a 3x3 job:
  - No lost or duplicated results and order is preserved.
  - The credit count reads FIFO_DEPTH when done fires.
- m_rows=0, n_cols=5: no a_rd_en or res_valid at all. done at T+1, busy high for exactly one cycle.
- Pulse start mid-job (m=2, n=2): ignored, and the job output is identical to the undisturbed run.
- Assert rst_n=0 after 3 issues of a 3x3 job:
  - All outputs go to 0 immediately.
  - After release, no stale res_valid appears.
  - A new 1x1 job yields a single result with res_last=1.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared definitions for the matmul dot-product scheduler: float width, FSM encoding
// and the tag layout {valid, row, col, last} (the last flag sits at bit 0).
`define TAG_WIDTH(RB, CB) ((RB) + (CB) + 2)

package matmul_pkg;

  localparam int FLOAT_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int TAG_LAST_POS = 0;
  localparam int TAG_COL_LSB  = 1;

  function automatic int tag_row_lsb(input int cb);
    return TAG_COL_LSB + cb;
  endfunction

  function automatic int tag_valid_pos(input int rb, input int cb);
    return TAG_COL_LSB + cb + rb;
  endfunction

  function automatic int tag_width(input int rb, input int cb);
    return `TAG_WIDTH(rb, cb);
  endfunction

endpackage

// File: rtl/sched_result_fifo.sv
// Show-ahead synchronous FIFO: o_dout is the head entry; a write is visible one cycle later.
// A push while full or a pop while empty is ignored; the producer must track free space itself.
module sched_result_fifo #(
  parameter int WIDTH = 41,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_empty,
  output logic             o_full
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_dout  = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int k = 0; k < DEPTH; k++) r_mem[k] <= '0;
    end else begin
      if (i_push && !o_full) begin
        r_mem[r_wr_ptr[AW-1:0]] <= i_din;
        r_wr_ptr                <= r_wr_ptr + 1'b1;
      end
      if (i_pop && !o_empty) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/matmul_dot_sched.sv
// Walks C row-major, issuing A-row/B-col reads to a shared vec_dot; first result appears
// RD_LATENCY+DOT_LATENCY+2 cycles after start. Issues stall on zero credits, so the non-stallable pipe never overflows the FIFO.
module matmul_dot_sched
  import matmul_pkg::*;
#(
  parameter int FLOAT_WIDTH = matmul_pkg::FLOAT_WIDTH,
  parameter int ROW_BITS    = 4,
  parameter int COL_BITS    = 4,
  parameter int RD_LATENCY  = 1,
  parameter int DOT_LATENCY = 4,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_start,
  input  logic [ROW_BITS-1:0]    i_m_rows,
  input  logic [COL_BITS-1:0]    i_n_cols,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_a_rd_en,
  output logic [ROW_BITS-1:0]    o_a_rd_addr,
  output logic                   o_b_rd_en,
  output logic [COL_BITS-1:0]    o_b_rd_addr,
  input  logic [FLOAT_WIDTH-1:0] i_dot_out,
  output logic                   o_res_valid,
  input  logic                   i_res_ready,
  output logic [FLOAT_WIDTH-1:0] o_res_data,
  output logic [ROW_BITS-1:0]    o_res_row,
  output logic [COL_BITS-1:0]    o_res_col,
  output logic                   o_res_last
);

  localparam int PIPE_DEPTH = RD_LATENCY + DOT_LATENCY;
  localparam int TW         = tag_width(ROW_BITS, COL_BITS);
  localparam int ROW_LSB    = tag_row_lsb(COL_BITS);
  localparam int VLD_POS    = tag_valid_pos(ROW_BITS, COL_BITS);
  localparam int CW         = $clog2(FIFO_DEPTH) + 1;
  localparam int FW         = FLOAT_WIDTH + ROW_BITS + COL_BITS + 1;

  state_e              r_state;
  state_e              w_state_nxt;
  logic [ROW_BITS-1:0] r_m_rows;
  logic [COL_BITS-1:0] r_n_cols;
  logic [ROW_BITS-1:0] r_i;
  logic [COL_BITS-1:0] r_j;
  logic [CW-1:0]       r_credits;
  logic                r_last_popped;
  logic [TW-1:0]       r_tag_pipe [PIPE_DEPTH];

  logic          w_issue;
  logic          w_issue_last;
  logic          w_pop;
  logic          w_push;
  logic          w_tags_idle;
  logic          w_fifo_empty;
  logic          w_fifo_full;
  logic [TW-1:0] w_tag_in;
  logic [TW-1:0] w_tag_out;
  logic [FW-1:0] w_fifo_din;
  logic [FW-1:0] w_fifo_dout;

  assign w_issue      = (r_state == ST_ISSUE) && (r_credits != '0);
  assign w_issue_last = w_issue && (r_i == r_m_rows - 1'b1) && (r_j == r_n_cols - 1'b1);
  assign w_pop        = o_res_valid && i_res_ready;

  assign o_busy      = (r_state != ST_IDLE);
  assign o_done      = (r_state == ST_DONE);
  assign o_a_rd_en   = w_issue;
  assign o_b_rd_en   = w_issue;
  assign o_a_rd_addr = r_i;
  assign o_b_rd_addr = r_j;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state_nxt = ((i_m_rows == '0) || (i_n_cols == '0)) ? ST_DONE : ST_ISSUE;
        end
      end
      ST_ISSUE: if (w_issue_last) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (w_tags_idle && w_fifo_empty && r_last_popped) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // The final issue leaves i/j untouched so the addresses keep showing the last element.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m_rows      <= '0;
      r_n_cols      <= '0;
      r_i           <= '0;
      r_j           <= '0;
      r_last_popped <= 1'b0;
    end else begin
      if ((r_state == ST_IDLE) && i_start) begin
        r_m_rows      <= i_m_rows;
        r_n_cols      <= i_n_cols;
        r_i           <= '0;
        r_j           <= '0;
        r_last_popped <= 1'b0;
      end else if (w_issue && !w_issue_last) begin
        if (r_j == r_n_cols - 1'b1) begin
          r_j <= '0;
          r_i <= r_i + 1'b1;
        end else begin
          r_j <= r_j + 1'b1;
        end
      end
      if (w_pop && o_res_last) r_last_popped <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_credits <= CW'(FIFO_DEPTH);
    end else begin
      case ({w_issue, w_pop})
        2'b10:   r_credits <= r_credits - 1'b1;
        2'b01:   r_credits <= r_credits + 1'b1;
        default: r_credits <= r_credits;
      endcase
    end
  end

  assign w_tag_in  = {w_issue, r_i, r_j, w_issue_last};
  assign w_tag_out = r_tag_pipe[PIPE_DEPTH-1];
  assign w_push    = w_tag_out[VLD_POS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < PIPE_DEPTH; k++) r_tag_pipe[k] <= '0;
    end else begin
      r_tag_pipe[0] <= w_tag_in;
      for (int k = 1; k < PIPE_DEPTH; k++) r_tag_pipe[k] <= r_tag_pipe[k-1];
    end
  end

  always_comb begin
    w_tags_idle = 1'b1;
    for (int k = 0; k < PIPE_DEPTH; k++) begin
      if (r_tag_pipe[k][VLD_POS]) w_tags_idle = 1'b0;
    end
  end

  assign w_fifo_din = {w_tag_out[ROW_LSB +: ROW_BITS], w_tag_out[TAG_COL_LSB +: COL_BITS],
                       w_tag_out[TAG_LAST_POS], i_dot_out};

  sched_result_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_res_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_din   (w_fifo_din),
    .i_pop   (w_pop),
    .o_dout  (w_fifo_dout),
    .o_empty (w_fifo_empty),
    .o_full  (w_fifo_full)
  );

  assign o_res_valid = !w_fifo_empty;
  assign o_res_data  = w_fifo_dout[FLOAT_WIDTH-1:0];
  assign o_res_last  = w_fifo_dout[FLOAT_WIDTH];
  assign o_res_col   = w_fifo_dout[FLOAT_WIDTH+1 +: COL_BITS];
  assign o_res_row   = w_fifo_dout[FLOAT_WIDTH+1+COL_BITS +: ROW_BITS];

  a_fifo_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(w_push && w_fifo_full));
  a_credit_bound:     assert property (@(posedge clk) disable iff (!rst_n) r_credits <= CW'(FIFO_DEPTH));

endmodule

// File: tb/tb_matmul_dot_sched.sv
// Directed bench for matmul_dot_sched; a behavioural vec_dot returns 0xA500_0000 + i*256 + j
// exactly RD_LATENCY+DOT_LATENCY cycles after each issue.
module tb_matmul_dot_sched;

  localparam int LAT = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  m_rows = '0;
  logic [3:0]  n_cols = '0;
  logic [31:0] dot_out = '0;
  logic        res_ready = 1'b0;
  logic        busy, done, a_rd_en, b_rd_en, res_valid, res_last;
  logic [3:0]  a_rd_addr, b_rd_addr, res_row, res_col;
  logic [31:0] res_data;
  logic [53:0] w_outs;

  matmul_dot_sched dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_start     (start),
    .i_m_rows    (m_rows),
    .i_n_cols    (n_cols),
    .o_busy      (busy),
    .o_done      (done),
    .o_a_rd_en   (a_rd_en),
    .o_a_rd_addr (a_rd_addr),
    .o_b_rd_en   (b_rd_en),
    .o_b_rd_addr (b_rd_addr),
    .i_dot_out   (dot_out),
    .o_res_valid (res_valid),
    .i_res_ready (res_ready),
    .o_res_data  (res_data),
    .o_res_row   (res_row),
    .o_res_col   (res_col),
    .o_res_last  (res_last)
  );

  assign w_outs = {busy, done, a_rd_en, b_rd_en, a_rd_addr, b_rd_addr,
                   res_valid, res_last, res_row, res_col, res_data};

  always #5 clk = ~clk;

  typedef struct { int c; int i; int j; } iss_t;
  typedef struct { int c; int i; int j; int last; logic [31:0] d; } res_t;
  typedef struct { int c; logic [31:0] v; } dot_t;

  iss_t iss_q[$];
  res_t res_q[$];
  dot_t dq[$];

  int cyc = 0;
  int t_start = -1;
  int done_cnt = 0, done_c = -1, busy_cyc = 0, vld_cyc = 0;
  int strobe_err = 0, stab_err = 0, credits_at_done = -1;
  int n_chk = 0, n_fail = 0;
  logic        hold = 1'b0;
  logic [40:0] hold_pl = '0;

  function automatic logic [31:0] dot_val(input int i, input int j);
    return 32'hA500_0000 + 32'(i * 256 + j);
  endfunction

  task automatic check(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // vec_dot model: replays each issued operand pair LAT cycles later.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (dq.size() > 0 && dq[0].c == cyc - LAT) begin
      dot_out = dq[0].v;
      void'(dq.pop_front());
    end else begin
      dot_out = 32'hDEAD_BEEF;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) dq.delete();
    if (a_rd_en != b_rd_en) strobe_err++;
    if (a_rd_en) begin
      iss_q.push_back('{cyc, int'(a_rd_addr), int'(b_rd_addr)});
      dq.push_back('{cyc, dot_val(int'(a_rd_addr), int'(b_rd_addr))});
    end
    if (rst_n && start && !busy) t_start = cyc;
    if (busy) busy_cyc++;
    if (res_valid) vld_cyc++;
    if (done) begin
      done_cnt++;
      done_c = cyc;
      credits_at_done = int'(dut.r_credits);
    end
    if (hold && res_valid && ({res_data, res_row, res_col, res_last} != hold_pl)) stab_err++;
    hold    = res_valid && !res_ready;
    hold_pl = {res_data, res_row, res_col, res_last};
    if (res_valid && res_ready)
      res_q.push_back('{cyc, int'(res_row), int'(res_col), int'(res_last), res_data});
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    iss_q.delete();
    res_q.delete();
    done_cnt = 0;
    done_c   = -1;
    busy_cyc = 0;
    vld_cyc  = 0;
    t_start  = -1;
  endtask

  task automatic do_start(input int m, input int n);
    start  = 1'b1;
    m_rows = 4'(m);
    n_cols = 4'(n);
    tick(1);
    start  = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    for (int k = 0; k < budget && done_cnt == 0; k++) tick(1);
    tick(2);
    check({tag, "_done_cnt"}, done_cnt, 1);
  endtask

  task automatic check_results(input string tag, input int m, input int n, input bit timed);
    check({tag, "_nres"}, res_q.size(), m * n);
    for (int k = 0; k < res_q.size() && k < m * n; k++) begin
      int ei;
      int ej;
      ei = k / n;
      ej = k % n;
      check(tag,
            {8'(timed ? res_q[k].c - t_start : 0), 4'(res_q[k].i), 4'(res_q[k].j),
             1'(res_q[k].last), res_q[k].d},
            {8'(timed ? 7 + k : 0), 4'(ei), 4'(ej), 1'(k == m * n - 1), dot_val(ei, ej)});
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", w_outs, 0);
    check("reset_credits", dut.r_credits, 8);
    rst_n = 1'b1;
    tick(2);

    // 2x3, always ready: exact issue/result/done timing.
    clear_logs();
    res_ready = 1'b1;
    do_start(2, 3);
    wait_done("t1", 60);
    check("t1_niss", iss_q.size(), 6);
    for (int k = 0; k < iss_q.size() && k < 6; k++)
      check("t1_issue", {8'(iss_q[k].c - t_start), 4'(iss_q[k].i), 4'(iss_q[k].j)},
            {8'(k + 1), 4'(k / 3), 4'(k % 3)});
    check_results("t1_res", 2, 3, 1'b1);
    check("t1_done_time", done_c - t_start, 14);

    // 4x4 with downstream stalled: credits cap issues at the FIFO depth.
    clear_logs();
    res_ready = 1'b0;
    do_start(4, 4);
    tick(20);
    check("t2_stalled_issues", iss_q.size(), 8);
    check("t2_rd_en_low", a_rd_en, 0);
    check("t2_no_pop_yet", res_q.size(), 0);
    res_ready = 1'b1;
    wait_done("t2", 100);
    check("t2_total_issues", iss_q.size(), 16);
    check_results("t2_res", 4, 4, 1'b0);

    // 3x3 with res_ready toggling every cycle.
    clear_logs();
    res_ready = 1'b0;
    do_start(3, 3);
    for (int k = 0; k < 200 && done_cnt == 0; k++) begin
      res_ready = ~res_ready;
      tick(1);
    end
    res_ready = 1'b1;
    tick(2);
    check("t3_done_cnt", done_cnt, 1);
    check_results("t3_res", 3, 3, 1'b0);
    check("t3_credits_at_done", credits_at_done, 8);

    // Zero-sized job.
    clear_logs();
    do_start(0, 5);
    tick(6);
    check("t4_issues", iss_q.size(), 0);
    check("t4_res_valid_cycles", vld_cyc, 0);
    check("t4_done_cnt", done_cnt, 1);
    check("t4_done_time", done_c - t_start, 1);
    check("t4_busy_cycles", busy_cyc, 1);

    // start pulse in the middle of a 2x2 job must be ignored.
    clear_logs();
    do_start(2, 2);
    tick(1);
    start  = 1'b1;
    m_rows = 4'd1;
    n_cols = 4'd1;
    tick(1);
    start  = 1'b0;
    wait_done("t5", 60);
    check("t5_niss", iss_q.size(), 4);
    check_results("t5_res", 2, 2, 1'b1);
    check("t5_done_time", done_c - t_start, 12);

    // Reset after three issues of a 3x3 job.
    clear_logs();
    do_start(3, 3);
    for (int k = 0; k < 20 && iss_q.size() < 3; k++) tick(1);
    check("t6_issues_before_reset", iss_q.size(), 3);
    clear_logs();
    rst_n = 1'b0;
    #1;
    check("t6_reset_outputs", w_outs, 0);
    @(posedge clk);
    #1;
    tick(2);
    rst_n = 1'b1;
    tick(15);
    check("t6_stale_res_valid", vld_cyc, 0);
    check("t6_no_done", done_cnt, 0);
    check("t6_credits_restored", dut.r_credits, 8);
    clear_logs();
    do_start(1, 1);
    wait_done("t6", 40);
    check_results("t6_res", 1, 1, 1'b1);

    check("strobes_identical", strobe_err, 0);
    check("payload_stable_on_stall", stab_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
